// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------------------------
// lsu_mem_master: load/store initiator between the execute stage and a word-wide data memory.
//
// Takes one byte/half/word load or store at a time, drives the memory's word port and returns a
// single-cycle response. Loads are sign/zero extended. Sub-word stores are read-modify-write.
// Misaligned accesses, the reserved size and out-of-range words are rejected without touching
// memory.
//
// Ports
//   clk          in   clock, rising edge
//   rstn         in   synchronous active-low reset
//   req_valid    in   request present
//   req_ready    out  block is idle and can accept
//   req_we       in   1 = store, 0 = load
//   req_size     in   0 byte, 1 half, 2 word, 3 reserved
//   req_unsigned in   loads: 1 zero-extend, 0 sign-extend
//   req_addr     in   byte address
//   req_wdata    in   store data, right-justified
//   rsp_valid    out  one-cycle completion pulse
//   rsp_rdata    out  extended load data (0 for stores and errors), held until next response
//   rsp_err      out  access rejected, held until next response
//   mem_we       out  memory write enable (forced low while rstn is low)
//   mem_addr     out  word-aligned byte address
//   mem_wdata    out  full word to write
//   mem_rdata    in   read data, valid the cycle after mem_addr with mem_we low
// ---------------------------------------------------------------------------------------------
module lsu_mem_master #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRd    = 3'd1,
    StCap   = 3'd2,
    StWr    = 3'd3,
    StMerge = 3'd4,
    StResp  = 3'd5
  } state_e;

  state_e      state_q;

  // Latched request fields
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  // Registered outputs
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;

  logic        acc_err;
  logic [31:0] load_ext;
  logic [31:0] merge_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Accept-time error check on the live request fields.
  always_comb begin
    acc_err = 1'b0;
    case (req_size)
      SzByte:  acc_err = 1'b0;
      SzHalf:  acc_err = req_addr[0];
      SzWord:  acc_err = (req_addr[1:0] != 2'b00);
      default: acc_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS) begin
      acc_err = 1'b1;
    end
  end

  // Lane extraction and extension of the word returned by the memory.
  always_comb begin
    rd_byte  = mem_rdata[{lane_q, 3'b000} +: 8];
    rd_half  = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    load_ext = mem_rdata;
    case (size_q)
      SzByte:  load_ext = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SzHalf:  load_ext = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Read-modify-write: replace only the addressed lane of the word just read.
  always_comb begin
    merge_word = mem_rdata;
    case (size_q)
      SzByte:  merge_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      SzHalf:  merge_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merge_word = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      size_q      <= SzByte;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
    end else begin
      rsp_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata;
            if (acc_err) begin
              // Rejected: mem_addr is left alone so no bad index ever reaches the memory.
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'h0;
            end else begin
              mem_addr_q <= {req_addr[31:2], 2'b00};
              if (req_we && (req_size == SzWord)) begin
                state_q  <= StWr;
                mem_we_q <= 1'b1;
              end else begin
                state_q <= StRd;
              end
            end
          end
        end
        StRd: begin
          if (we_q) begin
            state_q  <= StMerge;
            mem_we_q <= 1'b1;
          end else begin
            state_q <= StCap;
          end
        end
        StCap: begin
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= load_ext;
        end
        StWr, StMerge: begin
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'h0;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  // Gate with rstn so a reset landing on a write cycle cannot commit a partial transaction.
  assign mem_we    = mem_we_q & rstn;

  // MERGE must use mem_rdata live: it is only valid in this cycle.
  always_comb begin
    mem_wdata = 32'h0;
    if (state_q == StWr) begin
      mem_wdata = wdata_q;
    end else if (state_q == StMerge) begin
      mem_wdata = merge_word;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];

  int errors;
  int checks;

  lsu_mem_master #(
    .MEM_WORDS(64)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous word memory: registered read, write committed at the edge ending the we cycle.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and observe cycles 1..8 after the accept edge.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int rsp_cyc, output int rsp_cnt, output logic [31:0] rd,
                         output logic er, output int we_cnt, output int we_cyc,
                         output logic [31:0] we_data);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    check_eq("ready_before_accept", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    // Scramble the fields: the block must work from its latched copy.
    req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_F00D;
    rsp_cyc = -1; rsp_cnt = 0; rd = 32'hX; er = 1'bX;
    we_cnt = 0; we_cyc = -1; we_data = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++; we_cyc = c; we_data = mem_wdata;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_cyc < 0) begin
          rsp_cyc = c; rd = rsp_rdata; er = rsp_err;
        end
      end
    end
  endtask

  int          rc, rn, wc, wy;
  logic [31:0] rd, wdat;
  logic        er;

  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp);
    run_req(1'b0, sz, uns, addr, 32'h0, rc, rn, rd, er, wc, wy, wdat);
    check_eq({tag, "_cyc"}, 32'(rc), 32'd3);
    check_eq({tag, "_cnt"}, 32'(rn), 32'd1);
    check_eq({tag, "_data"}, rd, exp);
    check_eq({tag, "_err"}, {31'h0, er}, 32'h0);
    check_eq({tag, "_nowe"}, 32'(wc), 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input int exp_we_cyc,
                          input logic [31:0] exp_word);
    run_req(1'b1, sz, 1'b0, addr, wd, rc, rn, rd, er, wc, wy, wdat);
    check_eq({tag, "_cyc"}, 32'(rc), 32'(exp_we_cyc + 1));
    check_eq({tag, "_data"}, rd, 32'h0);
    check_eq({tag, "_err"}, {31'h0, er}, 32'h0);
    check_eq({tag, "_wecnt"}, 32'(wc), 32'd1);
    check_eq({tag, "_wecyc"}, 32'(wy), 32'(exp_we_cyc));
    check_eq({tag, "_wdata"}, wdat, exp_word);
  endtask

  task automatic do_bad(input string tag, input logic we, input logic [1:0] sz,
                        input logic [31:0] addr);
    run_req(we, sz, 1'b0, addr, 32'hFFFF_FFFF, rc, rn, rd, er, wc, wy, wdat);
    check_eq({tag, "_cyc"}, 32'(rc), 32'd1);
    check_eq({tag, "_cnt"}, 32'(rn), 32'd1);
    check_eq({tag, "_err"}, {31'h0, er}, 32'h1);
    check_eq({tag, "_data"}, rd, 32'h0);
    check_eq({tag, "_nowe"}, 32'(wc), 32'd0);
  endtask

  initial begin
    int n_ready;
    int n_rsp;
    int n_we;
    errors = 0; checks = 0;
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    rstn = 1'b1;

    // Preload through the block itself.
    do_store("pre_w5", 2'd2, 32'h14, 32'h8899_AABB, 1, 32'h8899_AABB);
    do_store("pre_w63", 2'd2, 32'hFC, 32'h7F00_0000, 1, 32'h7F00_0000);

    do_load("lb_s_15", 2'd0, 1'b0, 32'h15, 32'hFFFF_FFAA);
    do_load("lb_u_17", 2'd0, 1'b1, 32'h17, 32'h0000_0088);
    do_load("lh_u_16", 2'd1, 1'b1, 32'h16, 32'h0000_8899);
    do_load("lh_s_16", 2'd1, 1'b0, 32'h16, 32'hFFFF_8899);
    do_load("lh_s_14", 2'd1, 1'b0, 32'h14, 32'hFFFF_AABB);
    do_load("lw_14", 2'd2, 1'b0, 32'h14, 32'h8899_AABB);
    do_load("lb_u_ff", 2'd0, 1'b1, 32'hFF, 32'h0000_007F);

    do_store("sb_14", 2'd0, 32'h14, 32'hFFFF_FF55, 2, 32'h8899_AA55);
    do_load("lw_14_after_sb", 2'd2, 1'b0, 32'h14, 32'h8899_AA55);

    do_store("sw_20", 2'd2, 32'h20, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
    do_store("sh_22", 2'd1, 32'h22, 32'hABCD_1234, 2, 32'h1234_BEEF);
    do_load("lw_20", 2'd2, 1'b0, 32'h20, 32'h1234_BEEF);

    // rsp_rdata is non-zero here, so errors must actively clear it.
    do_bad("bad_h13", 1'b0, 2'd1, 32'h13);
    do_bad("bad_w16", 1'b1, 2'd2, 32'h16);
    do_bad("bad_sz3", 1'b0, 2'd3, 32'h14);
    do_bad("bad_oor", 1'b1, 2'd2, 32'h100);
    do_load("lw_20_after_bad", 2'd2, 1'b0, 32'h20, 32'h1234_BEEF);

    // Reset landing on the MERGE cycle of a byte store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h20; req_wdata = 32'hAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    check_eq("abort_merge_we", {31'h0, mem_we}, 32'h0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", {31'h0, req_ready}, 32'h1);
    n_rsp = 0;
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid) n_rsp++;
      @(negedge clk);
    end
    check_eq("abort_no_rsp", 32'(n_rsp), 32'd0);
    do_load("lw_20_after_abort", 2'd2, 1'b0, 32'h20, 32'h1234_BEEF);

    // req_valid held high: accepts only happen from IDLE, one every four cycles.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h14;
    n_ready = 0; n_rsp = 0; n_we = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (req_ready) n_ready++;
      if (rsp_valid) n_rsp++;
      if (mem_we) n_we++;
    end
    req_valid = 1'b0;
    check_eq("b2b_accepts", 32'(n_ready), 32'd3);
    check_eq("b2b_rsps", 32'(n_rsp), 32'd3);
    check_eq("b2b_nowe", 32'(n_we), 32'd0);
    check_eq("b2b_data", rsp_rdata, 32'h8899_AA55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
